uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of uart_tx on the same serial link. Format is 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, idle high. The block oversamples the asynchronous rx line with the system clock, samples each bit at its centre, and presents the received byte with a one-cycle done strobe. Default timing is 50 MHz / 115200 baud.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int DEFAULT_CLOCKS_PER_BIT = 434;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
module uart_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and
// presents the byte with a one-cycle done strobe.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | confirming the start bit at its centre
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit at its centre
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] readdata,
  output logic                 done,
  output logic                 active,
  output logic                 frame_error
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_t               state, state_next;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 cnt_clr;
  logic                 shift_en;
  logic                 done_d;
  logic                 ferr_d;

  uart_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      DATA:      if (cnt == CNT_MAX && bit_idx == LAST_BIT) state_next = STOP;
      STOP:      if (cnt == CNT_MAX) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    active   = 1'b0;
    shift_en = 1'b0;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    unique case (state)
      START: active = 1'b1;
      DATA: begin
        active   = 1'b1;
        shift_en = (cnt == CNT_MAX);
      end
      STOP: begin
        active = 1'b1;
        done_d = (cnt == CNT_MAX) && rx_s;
        ferr_d = (cnt == CNT_MAX) && !rx_s;
      end
      default: ;
    endcase
  end

  // Idle states park the counter at zero; within DATA it restarts every bit.
  assign cnt_clr = (state_next != state) || (cnt == CNT_MAX) ||
                   (state == IDLE) || (state == WAIT_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      readdata    <= '0;
      done        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cnt         <= cnt_clr ? '0 : cnt + 1'b1;
      done        <= done_d;
      frame_error <= ferr_d;
      if (state == START) bit_idx <= '0;
      if (shift_en) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (done_d) readdata <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, expected bytes
// queued at drive time and matched against each done strobe.
module tb_uart_rx;

  localparam int CPB = 434;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] readdata;
  logic       done;
  logic       active;
  logic       frame_error;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [7:0] sb_q[$];

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .readdata    (readdata),
    .done        (done),
    .active      (active),
    .frame_error (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (done || frame_error) chk("done_ferr_excl", {31'd0, done && frame_error}, 0);
    if (frame_error) ferr_cnt++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sb_q.size() == 0) chk("spurious_done", 1, 0);
      else chk("rx_byte", {24'd0, readdata}, {24'd0, sb_q.pop_front()});
    end
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) sb_q.push_back(b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
  endtask

  logic [7:0] prev;
  logic       seen;
  int         act_cycles;
  int         t0;
  int         lat;
  int         d0;
  int         f0;

  initial begin
    rx = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_readdata", {24'd0, readdata}, 0);
    chk("rst_active", {31'd0, active}, 0);
    reset = 1'b1;

    // 1: idle line stays quiet
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clock);
      if (done || active || frame_error || readdata != 8'h00) seen = 1'b1;
    end
    chk("idle_quiet", {31'd0, seen}, 0);

    // 2: single frame, activity latency and done latency
    @(posedge clock);
    t0 = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (4) @(negedge clock);
        chk("active_rise", {31'd0, active}, 1);
      end
    join
    idle(20);
    chk("a5_done_cnt", done_cnt, 1);
    lat = last_done_cyc - t0 - 1;
    chk("a5_latency", {31'd0, (lat >= 4124 && lat <= 4128)}, 1);
    chk("a5_readdata", {24'd0, readdata}, 32'hA5);

    // 3: back-to-back frames
    foreach (sb_q[i]) chk("sb_leftover", 1, 0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hAC, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hAF, 1'b1);
    idle(20);
    chk("b2b_done_cnt", done_cnt, 6);
    chk("b2b_ferr_cnt", ferr_cnt, 0);

    // 4: start-bit glitch
    prev = readdata;
    d0 = done_cnt;
    act_cycles = 0;
    @(posedge clock);
    rx = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 100) rx = 1'b1;
      @(negedge clock);
      if (active) act_cycles++;
    end
    chk("glitch_active_len", {31'd0, (act_cycles >= 214 && act_cycles <= 222)}, 1);
    chk("glitch_no_done", done_cnt, d0);
    chk("glitch_no_ferr", ferr_cnt, 0);
    chk("glitch_readdata", {24'd0, readdata}, {24'd0, prev});

    // 5: framing error then break
    prev = readdata;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (active) seen = 1'b1;
    end
    chk("break_inactive", {31'd0, seen}, 0);
    chk("ferr_once", ferr_cnt, f0 + 1);
    chk("ferr_no_done", done_cnt, d0);
    chk("ferr_readdata", {24'd0, readdata}, {24'd0, prev});
    idle(2 * CPB);
    send_byte(8'h81, 1'b1);
    idle(20);
    chk("post_break_done", done_cnt, d0 + 1);
    chk("post_break_data", {24'd0, readdata}, 32'h81);

    // 6: reset during data bit 4 of 0x55
    d0 = done_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clock);
    chk("mid_active", {31'd0, active}, 1);
    #3 reset = 1'b0;
    #1;
    chk("arst_active", {31'd0, active}, 0);
    chk("arst_readdata", {24'd0, readdata}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_ferr", {31'd0, frame_error}, 0);
    repeat (3) @(posedge clock);
    reset = 1'b1;
    idle(2 * CPB);
    chk("rst_no_done", done_cnt, d0);
    send_byte(8'h0F, 1'b1);
    idle(20);
    chk("post_rst_done", done_cnt, d0 + 1);
    chk("post_rst_data", {24'd0, readdata}, 32'h0F);
    chk("total_ferr", ferr_cnt, 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
